// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: mul/div FSM states,
// forward selects, ResultSrc codes and the forwarding-select helper.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;
  localparam int unsigned RES_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } muldiv_state_e;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  localparam logic [RES_W-1:0] RES_ALU  = 2'b00;
  localparam logic [RES_W-1:0] RES_LOAD = 2'b01;
  localparam logic [RES_W-1:0] RES_PC4  = 2'b10;

  // MEM beats WB; x0 is never a forwarding source.
  function automatic logic [FWD_W-1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] m_rd,
    input logic             m_we,
    input logic [REG_W-1:0] w_rd,
    input logic             w_we
  );
    logic [FWD_W-1:0] sel;
    sel = FWD_RF;
    if (m_we && (m_rd != '0) && (m_rd == rs)) begin
      sel = FWD_MEM;
    end else if (w_we && (w_rd != '0) && (w_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Mul/div EX occupancy sequencer: IDLE -> BUSY (latency-1 countdown) -> DONE.
// hold covers the start cycle and all BUSY cycles; done marks the DONE cycle.
module muldiv_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic hold,
  output logic done
);

  muldiv_state_e        state;
  logic [CNT_WIDTH-1:0] cnt;

  // Start is only sampled in IDLE so a stalled op cannot re-trigger itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_BUSY;
            cnt   <= is_div ? CNT_WIDTH'(DIV_CYCLES - 1) : CNT_WIDTH'(MUL_CYCLES - 1);
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign hold = ((state == ST_IDLE) && start) || (state == ST_BUSY);
  assign done = (state == ST_DONE);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage RV32 hazard controller: forwarding, load-use/branch handling and
// mul/div EX hold. Mul/div sequencing is built only with PIPE_CTRL_MULDIV_EN.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] D_Rs1,
  input  logic [REG_W-1:0] D_Rs2,
  input  logic [REG_W-1:0] E_Rs1,
  input  logic [REG_W-1:0] E_Rs2,
  input  logic [REG_W-1:0] E_Rd,
  input  logic [RES_W-1:0] E_ResultSrc,
  input  logic             E_PCSrc,
  input  logic             E_MulDivStart,
  input  logic             E_MulDivIsDiv,
  input  logic [REG_W-1:0] M_Rd,
  input  logic             M_RegWrite,
  input  logic [REG_W-1:0] W_Rd,
  input  logic             W_RegWrite,
  output logic [FWD_W-1:0] E_ForwardA,
  output logic [FWD_W-1:0] E_ForwardB,
  output logic             F_Stall,
  output logic             D_Stall,
  output logic             E_Stall,
  output logic             D_Flush,
  output logic             E_Flush,
  output logic             M_Flush,
  output logic             E_MulDivDone
);

  logic hold;
  logic done;
  logic load_use;

`ifdef PIPE_CTRL_MULDIV_EN
  muldiv_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_muldiv_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (E_MulDivStart),
    .is_div (E_MulDivIsDiv),
    .hold   (hold),
    .done   (done)
  );
`else
  logic unused_muldiv;

  assign hold = 1'b0;
  assign done = 1'b0;
  assign unused_muldiv = ^{clk, rst_n, E_MulDivStart, E_MulDivIsDiv,
                           32'(MUL_CYCLES), 32'(DIV_CYCLES), 32'(CNT_WIDTH)};
`endif

  assign E_ForwardA = fwd_sel(E_Rs1, M_Rd, M_RegWrite, W_Rd, W_RegWrite);
  assign E_ForwardB = fwd_sel(E_Rs2, M_Rd, M_RegWrite, W_Rd, W_RegWrite);

  assign load_use = (E_ResultSrc == RES_LOAD) && (E_Rd != '0) &&
                    ((E_Rd == D_Rs1) || (E_Rd == D_Rs2));

  // Priority merge: mul/div hold, then taken branch flush, then load-use bubble.
  always_comb begin
    F_Stall      = 1'b0;
    D_Stall      = 1'b0;
    E_Stall      = 1'b0;
    D_Flush      = 1'b0;
    E_Flush      = 1'b0;
    M_Flush      = 1'b0;
    E_MulDivDone = done;
    if (hold) begin
      F_Stall = 1'b1;
      D_Stall = 1'b1;
      E_Stall = 1'b1;
      M_Flush = 1'b1;
    end else if (E_PCSrc) begin
      D_Flush = 1'b1;
      E_Flush = 1'b1;
    end else if (load_use) begin
      F_Stall = 1'b1;
      D_Stall = 1'b1;
      E_Flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, mul/div timeline
// sequences, reset abort and randomized traffic against a timeline model.
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_CTRL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int MUL_L = 2;
  localparam int DIV_L = 33;

  logic       clk;
  logic       rst_n;
  logic [4:0] D_Rs1, D_Rs2, E_Rs1, E_Rs2, E_Rd, M_Rd, W_Rd;
  logic [1:0] E_ResultSrc;
  logic       E_PCSrc, E_MulDivStart, E_MulDivIsDiv, M_RegWrite, W_RegWrite;
  logic [1:0] E_ForwardA, E_ForwardB;
  logic       F_Stall, D_Stall, E_Stall, D_Flush, E_Flush, M_Flush, E_MulDivDone;
  logic [10:0] act;

  int checks;
  int failures;

  // Timeline model of the mul/div unit: op start is cycle 0, hold through L, done at L+1.
  bit m_active;
  int m_elapsed;
  int m_lat;

  pipeline_hazard_ctrl #(
    .MUL_CYCLES (MUL_L),
    .DIV_CYCLES (DIV_L),
    .CNT_WIDTH  (6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .D_Rs1        (D_Rs1),
    .D_Rs2        (D_Rs2),
    .E_Rs1        (E_Rs1),
    .E_Rs2        (E_Rs2),
    .E_Rd         (E_Rd),
    .E_ResultSrc  (E_ResultSrc),
    .E_PCSrc      (E_PCSrc),
    .E_MulDivStart(E_MulDivStart),
    .E_MulDivIsDiv(E_MulDivIsDiv),
    .M_Rd         (M_Rd),
    .M_RegWrite   (M_RegWrite),
    .W_Rd         (W_Rd),
    .W_RegWrite   (W_RegWrite),
    .E_ForwardA   (E_ForwardA),
    .E_ForwardB   (E_ForwardB),
    .F_Stall      (F_Stall),
    .D_Stall      (D_Stall),
    .E_Stall      (E_Stall),
    .D_Flush      (D_Flush),
    .E_Flush      (E_Flush),
    .M_Flush      (M_Flush),
    .E_MulDivDone (E_MulDivDone)
  );

  assign act = {E_ForwardA, E_ForwardB, F_Stall, D_Stall, E_Stall,
                D_Flush, E_Flush, M_Flush, E_MulDivDone};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] d_rs1, d_rs2, e_rs1, e_rs2, e_rd;
    logic [1:0] rsrc;
    logic       pcsrc;
    logic [4:0] m_rd;
    logic       m_we;
    logic [4:0] w_rd;
    logic       w_we;
    logic [1:0] exp_fa, exp_fb;
    logic       exp_fs, exp_ef, exp_df;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (M_RegWrite && M_Rd != 5'd0 && M_Rd == rs) return 2'b10;
    if (W_RegWrite && W_Rd != 5'd0 && W_Rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [10:0] ref_out(input bit hold, input bit done);
    bit lu;
    logic fs, ds, es, df, ef, mf;
    lu = (E_ResultSrc == 2'b01) && (E_Rd != 5'd0) && (E_Rd == D_Rs1 || E_Rd == D_Rs2);
    {fs, ds, es, df, ef, mf} = 6'b0;
    if (hold) {fs, ds, es, mf} = 4'b1111;
    else if (E_PCSrc) {df, ef} = 2'b11;
    else if (lu) {fs, ds, ef} = 3'b111;
    return {ref_fwd(E_Rs1), ref_fwd(E_Rs2), fs, ds, es, df, ef, mf, done};
  endfunction

  task automatic check_vec(input string nm, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (fa,fb,fs,ds,es,df,ef,mf,done)", nm, got, exp);
    end
  endtask

  task automatic check_bits(input string nm, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic check_model(input string nm);
    bit h, d;
    h = 1'b0;
    d = 1'b0;
    if (MD_EN) begin
      if (!m_active) h = E_MulDivStart;
      else begin
        h = (m_elapsed <= m_lat);
        d = (m_elapsed == m_lat + 1);
      end
    end
    check_vec(nm, act, ref_out(h, d));
  endtask

  task automatic model_advance();
    if (MD_EN) begin
      if (!m_active) begin
        if (E_MulDivStart) begin
          m_active  = 1'b1;
          m_elapsed = 1;
          m_lat     = E_MulDivIsDiv ? DIV_L : MUL_L;
        end
      end else if (m_elapsed == m_lat + 1) begin
        m_active = 1'b0;
      end else begin
        m_elapsed++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic zero_inputs();
    {D_Rs1, D_Rs2, E_Rs1, E_Rs2, E_Rd, M_Rd, W_Rd} = '0;
    E_ResultSrc   = 2'b00;
    E_PCSrc       = 1'b0;
    E_MulDivStart = 1'b0;
    E_MulDivIsDiv = 1'b0;
    M_RegWrite    = 1'b0;
    W_RegWrite    = 1'b0;
  endtask

  // One cycle of a mul/div op with explicit hold/done expectations.
  task automatic md_cycle(input string nm, input logic start, input logic is_div,
                          input logic exp_hold, input logic exp_done);
    E_MulDivStart = start;
    E_MulDivIsDiv = is_div;
    @(negedge clk);
    check_model(nm);
    check_bits({nm, "_hold_done"}, {E_Stall, E_MulDivDone},
               {exp_hold & MD_EN, exp_done & MD_EN});
    tick();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    m_active  = 1'b0;
    m_elapsed = 0;
    m_lat     = 0;
    rst_n     = 1'b0;
    zero_inputs();

    tbl[0]  = '{"fwd_mem",    5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{"fwd_wb",     5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{"fwd_x0",     5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{"fwd_b_mem",  5'd0, 5'd0, 5'd1, 5'd9, 5'd0, 2'b00, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{"fwd_split",  5'd0, 5'd0, 5'd3, 5'd4, 5'd0, 2'b00, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{"fwd_no_we",  5'd0, 5'd0, 5'd6, 5'd6, 5'd0, 2'b00, 1'b0, 5'd6, 1'b0, 5'd6, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{"lu_rs2",     5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{"lu_rs1",     5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{"lu_x0",      5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{"lu_alu",     5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{"lu_pc4",     5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{"br_over_lu", 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{"br_only",    5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{"bubble",     5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

    #3;
    check_vec("reset_outputs", act, 11'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_vec("post_reset_idle", act, 11'd0);
    tick();

    // Directed combinational vectors
    for (int i = 0; i < 14; i++) begin
      D_Rs1 = tbl[i].d_rs1;  D_Rs2 = tbl[i].d_rs2;
      E_Rs1 = tbl[i].e_rs1;  E_Rs2 = tbl[i].e_rs2;  E_Rd = tbl[i].e_rd;
      E_ResultSrc = tbl[i].rsrc;  E_PCSrc = tbl[i].pcsrc;
      M_Rd = tbl[i].m_rd;  M_RegWrite = tbl[i].m_we;
      W_Rd = tbl[i].w_rd;  W_RegWrite = tbl[i].w_we;
      @(negedge clk);
      check_bits({tbl[i].name, "_fwdA"}, E_ForwardA, tbl[i].exp_fa);
      check_bits({tbl[i].name, "_fwdB"}, E_ForwardB, tbl[i].exp_fb);
      check_bits({tbl[i].name, "_stall"}, {F_Stall, D_Stall}, {tbl[i].exp_fs, tbl[i].exp_fs});
      check_bits({tbl[i].name, "_flush"}, {D_Flush, E_Flush}, {tbl[i].exp_df, tbl[i].exp_ef});
      check_model(tbl[i].name);
      tick();
    end
    zero_inputs();

    // Back-to-back multiplies with start held high: hold 0..2, done 3, restart at 4
    for (int k = 0; k < 8; k++) md_cycle("mul_b2b", 1'b1, 1'b0, (k % 4) <= 2, (k % 4) == 3);
    md_cycle("mul_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Divide with start held through DONE: hold 0..33, done 34, then idle
    for (int k = 0; k < 35; k++) md_cycle("div", 1'b1, 1'b1, k <= 33, k == 34);
    md_cycle("div_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during a divide (BUSY cycle 10): outputs drop at once, no done later
    for (int k = 0; k < 10; k++) md_cycle("div_pre_rst", 1'b1, 1'b1, 1'b1, 1'b0);
    md_cycle("div_busy10", 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    zero_inputs();
    rst_n = 1'b0;
    #1;
    check_vec("rst_mid_outputs", act, 11'd0);
    m_active = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 40; k++) md_cycle("rst_no_done", 1'b0, 1'b0, 1'b0, 1'b0);

    // A fresh multiply after the abort must start from IDLE
    for (int k = 0; k < 4; k++) md_cycle("mul_after_rst", 1'b1, 1'b0, k <= 2, k == 3);
    md_cycle("mul_after_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      D_Rs1 = 5'($urandom_range(0, 3));
      D_Rs2 = 5'($urandom_range(0, 3));
      E_Rs1 = 5'($urandom_range(0, 3));
      E_Rs2 = 5'($urandom_range(0, 3));
      E_Rd  = 5'($urandom_range(0, 3));
      M_Rd  = 5'($urandom_range(0, 3));
      W_Rd  = 5'($urandom_range(0, 3));
      E_ResultSrc   = 2'($urandom_range(0, 3));
      E_PCSrc       = ($urandom_range(0, 7) == 0);
      M_RegWrite    = 1'($urandom);
      W_RegWrite    = 1'($urandom);
      E_MulDivStart = ($urandom_range(0, 15) == 0);
      E_MulDivIsDiv = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      check_model("random");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
